ace_rle_loader: RTL and testbench

//  Unpacks an .ACE snapshot streamed over the HPS ioctl download bus into Jupiter Ace RAM writes.

---
 rtl/ace_rle_loader_if.sv | 22 ++
 rtl/ace_rle_loader.sv | 193 +++++++++++++++++++
 tb/tb_ace_rle_loader.sv | 242 ++++++++++++++++++++++++
 3 files changed

// File: rtl/ace_rle_loader_if.sv
// Download-side (hps_io ioctl) and RAM-write-side signals of the .ACE snapshot loader.
// master = hps_io / RAM consumer side, slave = ace_rle_loader.
interface ace_rle_loader_if;
    logic        ioctl_download;
    logic [7:0]  ioctl_index;
    logic        ioctl_wr;
    logic [7:0]  ioctl_dout;
    logic        ioctl_wait;
    logic [15:0] mem_addr;
    logic [7:0]  mem_data;
    logic        mem_wr;

    modport master (
        output ioctl_download, ioctl_index, ioctl_wr, ioctl_dout,
        input  ioctl_wait, mem_addr, mem_data, mem_wr
    );

    modport slave (
        input  ioctl_download, ioctl_index, ioctl_wr, ioctl_dout,
        output ioctl_wait, mem_addr, mem_data, mem_wr
    );
endinterface

// File: rtl/ace_rle_loader.sv
// Expands an ED-escaped RLE .ACE snapshot from the ioctl download bus into Jupiter Ace RAM writes.
// Optional ACE_LOADER_STATS_EN adds byte_count / run_count statistics outputs.
module ace_rle_loader #(
    parameter logic [15:0] BASE_ADDR     = 16'h2000,
    parameter int unsigned SETTLE_CYCLES = 3000000,
    parameter int unsigned CNT_W         = 22
) (
    input  logic                   clk_sys,
    input  logic                   reset_n,
    ace_rle_loader_if.slave        bus,
    output logic                   loader_en,
    output logic                   core_reset,
    output logic                   load_err
`ifdef ACE_LOADER_STATS_EN
    ,
    output logic [15:0]            byte_count,
    output logic [7:0]             run_count
`endif
);

    typedef enum logic [2:0] {
        S_IDLE, S_LIT, S_CNT, S_VAL, S_FILL, S_SETTLE, S_DONE
    } state_t;

    localparam logic [7:0]       ESC_BYTE    = 8'hED;
    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);

    state_t             r_state;
    logic               r_dl_d;
    logic               r_wait;
    logic [15:0]        r_mem_addr;
    logic [7:0]         r_mem_data;
    logic               r_mem_wr;
    logic               r_loader_en;
    logic               r_core_reset;
    logic               r_load_err;
    logic [7:0]         r_run_len;
    logic [CNT_W-1:0]   r_settle;

    logic w_start;
    logic w_fall;
    logic w_take;
    logic w_violation;

    assign w_start     = bus.ioctl_download & ~r_dl_d & (bus.ioctl_index != 8'd0);
    assign w_fall      = ~bus.ioctl_download & r_dl_d;
    assign w_take      = bus.ioctl_wr & ~r_wait;
    assign w_violation = bus.ioctl_wr & r_wait;

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= S_IDLE;
            r_dl_d       <= 1'b0;
            r_wait       <= 1'b0;
            r_mem_addr   <= BASE_ADDR;
            r_mem_data   <= 8'd0;
            r_mem_wr     <= 1'b0;
            r_loader_en  <= 1'b0;
            r_core_reset <= 1'b0;
            r_load_err   <= 1'b0;
            r_run_len    <= 8'd0;
            r_settle     <= '0;
        end else begin
            r_dl_d       <= bus.ioctl_download;
            r_core_reset <= w_start;
            r_mem_wr     <= 1'b0;

            // Address advances after every write; wrapping past FFFF flags the load as bad.
            if (r_mem_wr) begin
                r_mem_addr <= r_mem_addr + 16'd1;
                if (r_mem_addr == 16'hFFFF)
                    r_load_err <= 1'b1;
            end
            if (w_violation)
                r_load_err <= 1'b1;

            if (w_start) begin
                // A new start aborts whatever was in progress.
                r_state    <= S_LIT;
                r_mem_addr <= BASE_ADDR;
                r_load_err <= 1'b0;
                r_wait     <= 1'b0;
            end else begin
                if (w_fall) begin
                    r_loader_en <= 1'b0;
                    if (r_state == S_CNT || r_state == S_VAL || r_state == S_FILL)
                        r_load_err <= 1'b1;
                end else if (w_take && r_state != S_IDLE) begin
                    r_loader_en <= 1'b1;
                end

                case (r_state)
                    S_IDLE: ;
                    S_LIT: begin
                        if (w_fall)
                            r_state <= S_IDLE;
                        else if (w_take) begin
                            if (bus.ioctl_dout == ESC_BYTE)
                                r_state <= S_CNT;
                            else begin
                                r_mem_wr   <= 1'b1;
                                r_mem_data <= bus.ioctl_dout;
                            end
                        end
                    end
                    S_CNT: begin
                        if (w_fall)
                            r_state <= S_IDLE;
                        else if (w_take) begin
                            r_run_len <= bus.ioctl_dout;
                            if (bus.ioctl_dout == 8'd0) begin
                                r_state  <= S_SETTLE;
                                r_wait   <= 1'b1;
                                r_settle <= '0;
                            end else begin
                                r_state <= S_VAL;
                            end
                        end
                    end
                    S_VAL: begin
                        // First fill write issues here so the run starts the cycle after the value byte.
                        if (w_fall)
                            r_state <= S_IDLE;
                        else if (w_take) begin
                            r_mem_wr   <= 1'b1;
                            r_mem_data <= bus.ioctl_dout;
                            r_wait     <= 1'b1;
                            r_run_len  <= r_run_len - 8'd1;
                            r_state    <= S_FILL;
                        end
                    end
                    S_FILL: begin
                        if (r_run_len != 8'd0) begin
                            r_mem_wr  <= 1'b1;
                            r_run_len <= r_run_len - 8'd1;
                        end else begin
                            r_wait  <= 1'b0;
                            r_state <= bus.ioctl_download ? S_LIT : S_IDLE;
                        end
                    end
                    S_SETTLE: begin
                        if (r_settle == SETTLE_LAST) begin
                            r_wait  <= 1'b0;
                            r_state <= bus.ioctl_download ? S_DONE : S_IDLE;
                        end else begin
                            r_settle <= r_settle + CNT_W'(1);
                        end
                    end
                    S_DONE: begin
                        if (w_fall)
                            r_state <= S_IDLE;
                    end
                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end

    assign bus.ioctl_wait = r_wait;
    assign bus.mem_addr   = r_mem_addr;
    assign bus.mem_data   = r_mem_data;
    assign bus.mem_wr     = r_mem_wr;
    assign loader_en      = r_loader_en;
    assign core_reset     = r_core_reset;
    assign load_err       = r_load_err;

`ifdef ACE_LOADER_STATS_EN
    logic [15:0] r_byte_count;
    logic [7:0]  r_run_count;
    logic        w_run_begin;

    assign w_run_begin = (r_state == S_VAL) & w_take & ~w_fall;

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            r_byte_count <= 16'd0;
            r_run_count  <= 8'd0;
        end else if (w_start) begin
            r_byte_count <= 16'd0;
            r_run_count  <= 8'd0;
        end else begin
            if (r_mem_wr && r_byte_count != 16'hFFFF)
                r_byte_count <= r_byte_count + 16'd1;
            if (w_run_begin && r_run_count != 8'hFF)
                r_run_count <= r_run_count + 8'd1;
        end
    end

    assign byte_count = r_byte_count;
    assign run_count  = r_run_count;
`endif

endmodule

// File: tb/tb_ace_rle_loader.sv
// Directed bench for ace_rle_loader: literal bytes, RLE runs, end marker/settle, ignored index,
// truncated stream and asynchronous reset during a long run.
module tb_ace_rle_loader;

    logic clk_sys;
    logic reset_n;
    logic loader_en;
    logic core_reset;
    logic load_err;
`ifdef ACE_LOADER_STATS_EN
    logic [15:0] byte_count;
    logic [7:0]  run_count;
`endif

    ace_rle_loader_if bus ();

    ace_rle_loader #(
        .BASE_ADDR     (16'h2000),
        .SETTLE_CYCLES (10),
        .CNT_W         (22)
    ) dut (
        .clk_sys    (clk_sys),
        .reset_n    (reset_n),
        .bus        (bus),
        .loader_en  (loader_en),
        .core_reset (core_reset),
        .load_err   (load_err)
`ifdef ACE_LOADER_STATS_EN
        ,
        .byte_count (byte_count),
        .run_count  (run_count)
`endif
    );

    initial begin
        clk_sys = 1'b0;
        forever #5 clk_sys = ~clk_sys;
    end

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    int wait_hi = 0;
    int rst_hi = 0;
    logic [15:0] log_addr[$];
    logic [7:0]  log_data[$];
    int          log_cyc[$];
    logic        log_wait[$];

    always @(posedge clk_sys) cyc <= cyc + 1;

    always @(negedge clk_sys) begin
        if (bus.mem_wr) begin
            log_addr.push_back(bus.mem_addr);
            log_data.push_back(bus.mem_data);
            log_cyc.push_back(cyc);
            log_wait.push_back(bus.ioctl_wait);
            $display("mem_wr addr=%04h data=%02h wait=%0b", bus.mem_addr, bus.mem_data, bus.ioctl_wait);
        end
        if (bus.ioctl_wait) wait_hi++;
        if (core_reset) rst_hi++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic expect_write(input string tag, input int idx, input logic [15:0] addr,
                                input logic [7:0] data);
        if (idx < log_addr.size()) begin
            check({tag, "_addr"}, 32'(log_addr[idx]), 32'(addr));
            check({tag, "_data"}, 32'(log_data[idx]), 32'(data));
        end else begin
            check({tag, "_missing"}, 32'(log_addr.size()), 32'(idx + 1));
        end
    endtask

    task automatic send(input logic [7:0] b);
        int guard;
        guard = 0;
        while (bus.ioctl_wait && guard < 100) begin
            @(negedge clk_sys);
            guard++;
        end
        if (guard >= 100) check("wait_timeout", 32'(guard), 32'd0);
        $display("ioctl_wr byte=%02h", b);
        bus.ioctl_dout = b;
        bus.ioctl_wr   = 1'b1;
        @(negedge clk_sys);
        bus.ioctl_wr   = 1'b0;
    endtask

    task automatic start_dl(input logic [7:0] idx);
        bus.ioctl_index    = idx;
        bus.ioctl_download = 1'b1;
        repeat (2) @(negedge clk_sys);
    endtask

    task automatic end_dl();
        bus.ioctl_download = 1'b0;
        repeat (4) @(negedge clk_sys);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: observed cycle %0d expected finish", cyc);
        $fatal(1, "bench timeout");
    end

    initial begin
        int b;
        int w0;
        int r0;
        reset_n            = 1'b0;
        bus.ioctl_download = 1'b0;
        bus.ioctl_index    = 8'd0;
        bus.ioctl_wr       = 1'b0;
        bus.ioctl_dout     = 8'd0;
        repeat (3) @(negedge clk_sys);

        // Reset state
        check("rst_mem_wr", 32'(bus.mem_wr), 32'd0);
        check("rst_wait", 32'(bus.ioctl_wait), 32'd0);
        check("rst_addr", 32'(bus.mem_addr), 32'h2000);
        check("rst_loader_en", 32'(loader_en), 32'd0);
        check("rst_core_reset", 32'(core_reset), 32'd0);
        check("rst_load_err", 32'(load_err), 32'd0);
        reset_n = 1'b1;
        repeat (2) @(negedge clk_sys);

        // 1: literal bytes
        b = log_addr.size(); r0 = rst_hi;
        start_dl(8'd1);
        send(8'h12); send(8'h34); send(8'h56);
        repeat (2) @(negedge clk_sys);
        check("t1_loader_en", 32'(loader_en), 32'd1);
        check("t1_core_reset_pulses", 32'(rst_hi - r0), 32'd1);
        check("t1_nwr", 32'(log_addr.size() - b), 32'd3);
        expect_write("t1_w0", b + 0, 16'h2000, 8'h12);
        expect_write("t1_w1", b + 1, 16'h2001, 8'h34);
        expect_write("t1_w2", b + 2, 16'h2002, 8'h56);
        check("t1_addr_after", 32'(bus.mem_addr), 32'h2003);
`ifdef ACE_LOADER_STATS_EN
        check("t1_byte_count", 32'(byte_count), 32'd3);
`endif
        end_dl();
        check("t1_loader_en_off", 32'(loader_en), 32'd0);

        // 2: run ED 04 AA then literal 77
        b = log_addr.size(); w0 = wait_hi;
        start_dl(8'd1);
        send(8'hED); send(8'h04); send(8'hAA); send(8'h77);
        repeat (3) @(negedge clk_sys);
        check("t2_nwr", 32'(log_addr.size() - b), 32'd5);
        for (int k = 0; k < 4; k++) begin
            expect_write($sformatf("t2_run%0d", k), b + k, 16'h2000 + 16'(k), 8'hAA);
            if (b + k < log_cyc.size()) begin
                check($sformatf("t2_run%0d_cycle", k), 32'(log_cyc[b + k] - log_cyc[b]), 32'(k));
                check($sformatf("t2_run%0d_wait", k), 32'(log_wait[b + k]), 32'd1);
            end
        end
        expect_write("t2_lit", b + 4, 16'h2004, 8'h77);
        if (b + 4 < log_wait.size()) check("t2_lit_wait", 32'(log_wait[b + 4]), 32'd0);
        check("t2_wait_cycles", 32'(wait_hi - w0), 32'd4);
`ifdef ACE_LOADER_STATS_EN
        check("t2_run_count", 32'(run_count), 32'd1);
`endif
        end_dl();

        // 3: escaped literal ED, end marker, settle, trailing byte discarded
        b = log_addr.size();
        start_dl(8'd1);
        send(8'hED); send(8'h01); send(8'hED); send(8'hED);
        w0 = wait_hi;
        send(8'h00); send(8'h99);
        repeat (5) @(negedge clk_sys);
        check("t3_nwr", 32'(log_addr.size() - b), 32'd1);
        expect_write("t3_w0", b, 16'h2000, 8'hED);
        check("t3_settle_wait", 32'(wait_hi - w0), 32'd10);
        check("t3_load_err", 32'(load_err), 32'd0);
        end_dl();

        // 4: index 0 download is ignored
        b = log_addr.size(); w0 = wait_hi; r0 = rst_hi;
        start_dl(8'd0);
        send(8'h11); send(8'hED); send(8'h02); send(8'h33); send(8'h00);
        repeat (3) @(negedge clk_sys);
        check("t4_nwr", 32'(log_addr.size() - b), 32'd0);
        check("t4_core_reset", 32'(rst_hi - r0), 32'd0);
        check("t4_wait", 32'(wait_hi - w0), 32'd0);
        end_dl();

        // 5: truncated stream sets load_err, next start clears it
        start_dl(8'd1);
        send(8'hED); send(8'h03);
        end_dl();
        check("t5_load_err", 32'(load_err), 32'd1);
        check("t5_loader_en", 32'(loader_en), 32'd0);
        b = log_addr.size();
        send(8'h55);
        repeat (3) @(negedge clk_sys);
        check("t5_idle_nwr", 32'(log_addr.size() - b), 32'd0);
        r0 = rst_hi;
        start_dl(8'd2);
        check("t5_err_cleared", 32'(load_err), 32'd0);
        check("t5_core_reset", 32'(rst_hi - r0), 32'd1);
        end_dl();

        // 6: async reset in the middle of a 255-byte fill
        start_dl(8'd1);
        send(8'hED); send(8'hFF); send(8'h00);
        repeat (3) @(negedge clk_sys);
        check("t6_fill_mem_wr", 32'(bus.mem_wr), 32'd1);
        check("t6_fill_wait", 32'(bus.ioctl_wait), 32'd1);
        reset_n = 1'b0;
        #1;
        check("t6_rst_mem_wr", 32'(bus.mem_wr), 32'd0);
        check("t6_rst_wait", 32'(bus.ioctl_wait), 32'd0);
        check("t6_rst_addr", 32'(bus.mem_addr), 32'h2000);
        check("t6_rst_loader_en", 32'(loader_en), 32'd0);
`ifdef ACE_LOADER_STATS_EN
        check("t6_rst_byte_count", 32'(byte_count), 32'd0);
        check("t6_rst_run_count", 32'(run_count), 32'd0);
`endif
        b = log_addr.size();
        repeat (2) @(negedge clk_sys);
        bus.ioctl_download = 1'b0;
        @(negedge clk_sys);
        reset_n = 1'b1;
        repeat (5) @(negedge clk_sys);
        check("t6_post_nwr", 32'(log_addr.size() - b), 32'd0);
        check("t6_post_wait", 32'(bus.ioctl_wait), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
